traffic_light_fsm: RTL



---
 rtl/traffic_light_fsm.sv | 105 ++++++++++
 1 files changed

// File: rtl/traffic_light_fsm.sv
// Highway/farm-road intersection controller: sequences both roads' lights from a
// synchronised car sensor and the expiry flags of two external interval timers.
module traffic_light_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       car,
  input  logic       TL_out,
  input  logic       TS_out,
  output logic       TL_start,
  output logic       TS_start,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_HG = 2'd0,
    S_HY = 2'd1,
    S_FG = 2'd2,
    S_FY = 2'd3
  } state_t;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_car_sync;
  logic                   w_car_s;
  logic                   w_hg_exit;
  logic                   w_hy_exit;
  logic                   w_fg_exit;
  logic                   w_fy_exit;

  // Car sensor is asynchronous; it enters the FSM only through this flop chain.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_car_sync <= '0;
    end else begin
      r_car_sync <= {r_car_sync[SYNC_STAGES-2:0], car};
    end
  end

  assign w_car_s = r_car_sync[SYNC_STAGES-1];

  assign w_hg_exit = (r_state == S_HG) && w_car_s && TL_out;
  assign w_hy_exit = (r_state == S_HY) && TS_out;
  assign w_fg_exit = (r_state == S_FG) && (!w_car_s || TL_out);
  assign w_fy_exit = (r_state == S_FY) && TS_out;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_HG;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HG:    if (w_hg_exit) w_state_next = S_HY;
      S_HY:    if (w_hy_exit) w_state_next = S_FG;
      S_FG:    if (w_fg_exit) w_state_next = S_FY;
      S_FY:    if (w_fy_exit) w_state_next = S_HG;
      default: w_state_next = S_HG;
    endcase
  end

  // Strobes fire on the transition cycle so the timer reads 0 in the new state's first cycle.
  always_comb begin
    TS_start   = w_hg_exit || w_fg_exit;
    TL_start   = w_hy_exit || w_fy_exit;
    hwy_light  = LIGHT_GREEN;
    farm_light = LIGHT_RED;
    case (r_state)
      S_HG: begin
        hwy_light  = LIGHT_GREEN;
        farm_light = LIGHT_RED;
      end
      S_HY: begin
        hwy_light  = LIGHT_YELLOW;
        farm_light = LIGHT_RED;
      end
      S_FG: begin
        hwy_light  = LIGHT_RED;
        farm_light = LIGHT_GREEN;
      end
      S_FY: begin
        hwy_light  = LIGHT_RED;
        farm_light = LIGHT_YELLOW;
      end
      default: begin
        hwy_light  = LIGHT_GREEN;
        farm_light = LIGHT_RED;
      end
    endcase
  end

  assign state_dbg = r_state;

endmodule
